// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: single-word request with a ready/data return.
// The fetch stage is the master; the memory (or its model) is the slave.
interface instruction_fetch_if;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one word per fetch pulse, holds it for decode,
// and substitutes a NOP on misaligned address or memory timeout.
module instruction_fetch #(
    parameter logic [31:0] BOOT_INSTR     = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_start,
    input  logic [31:0]                instruction_addr,
    instruction_fetch_if.master        mem,
    output logic [31:0]                instruction,
    output logic                       instruction_valid,
    output logic                       fetch_busy,
    output logic                       misaligned_fault,
    output logic                       bus_fault
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          read_q, read_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          mis_q, mis_d;
    logic          bus_q, bus_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic in_req;
    logic accept;
    logic aligned;
    logic hit;
    logic tmo;

    assign in_req  = (state_q == REQ);
    assign accept  = fetch_start && !in_req;
    assign aligned = (instruction_addr[1:0] == 2'b00);
    assign hit     = in_req && mem.mem_ready;
    // Data arriving in the final wait cycle wins over the timeout.
    assign tmo     = in_req && !mem.mem_ready && TMO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            addr_q  <= 32'h0;
            instr_q <= BOOT_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = aligned ? REQ : IDLE;
                end
            end
            REQ: begin
                if (hit) begin
                    state_d = DONE;
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_d  = read_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        mis_d   = mis_q;
        bus_d   = bus_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    valid_d = 1'b0;
                    mis_d   = 1'b0;
                    bus_d   = 1'b0;
                    if (!aligned) begin
                        mis_d   = 1'b1;
                        instr_d = BOOT_INSTR;
                    end else begin
                        addr_d = instruction_addr;
                        read_d = 1'b1;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            REQ: begin
                if (hit) begin
                    instr_d = mem.mem_rdata;
                    valid_d = 1'b1;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (tmo) begin
                    bus_d   = 1'b1;
                    instr_d = BOOT_INSTR;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                read_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign mem.mem_read      = read_q;
    assign mem.mem_addr      = addr_q;
    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign fetch_busy        = busy_q;
    assign misaligned_fault  = mis_q;
    assign bus_fault         = bus_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- On a fetch pulse from the stage sequencer, it takes the current instruction_addr and issues a single-word read to instruction memory over a valid/ready handshake.
- It captures the returned word and holds it stable for decode until the next fetch.
- It detects misaligned fetch addresses and memory timeouts, and substitutes a NOP on fault.

Parameters:
- BOOT_INSTR, 32'h00000013, word driven on instruction at reset and on any fault (ADDI x0,x0,0 NOP).
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ without mem_ready before a bus fault. 0 disables the timeout.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_start  input  1  one-cycle pulse from the stage sequencer: begin a fetch.
- instruction_addr  input  32  PC value; sampled only in the cycle fetch_start is accepted.
- mem_ready  input  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  input  32  memory read data; qualified by mem_ready.
- mem_read  output  1  read request to instruction memory.
- mem_addr  output  32  read address; stable while mem_read=1.
- instruction  output  32  last fetched instruction word, held between fetches.
- instruction_valid  output  1  instruction holds a completed, fault-free fetch.
- fetch_busy  output  1  fetch in progress (state REQ).
- misaligned_fault  output  1  last accepted fetch had instruction_addr[1:0] != 0.
- bus_fault  output  1  last accepted fetch timed out.

Behaviour:
- Reset values: state=IDLE, mem_read=0, mem_addr=0, instruction=BOOT_INSTR, instruction_valid=0, fetch_busy=0, misaligned_fault=0, bus_fault=0, wait counter=0. Reset has priority over every other event. Reset during REQ aborts the fetch: mem_read=0 after that edge, and no capture happens even if mem_ready=1 in the same cycle.
- States: IDLE, REQ, DONE. All outputs are registered.
- IDLE or DONE, fetch_start=1:
  - Clear instruction_valid, misaligned_fault and bus_fault.
  - If instruction_addr[1:0]!=0: set misaligned_fault=1, set instruction=BOOT_INSTR, go to IDLE. No memory request is issued.
  - Otherwise: mem_addr<=instruction_addr, mem_read<=1, fetch_busy<=1, wait counter<=0, go to REQ.
- REQ:
  - mem_addr and mem_read are held constant.
  - If mem_ready=1: instruction<=mem_rdata, instruction_valid<=1, mem_read<=0, fetch_busy<=0, go to DONE.
  - Else if TIMEOUT_CYCLES!=0 and wait counter==TIMEOUT_CYCLES-1: bus_fault<=1, instruction<=BOOT_INSTR, mem_read<=0, fetch_busy<=0, go to IDLE.
  - Else: increment the wait counter. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit, and it never wraps.
- DONE: instruction and instruction_valid are held until the next accepted fetch_start or reset.
- fetch_start while in REQ is ignored; it is neither queued nor counted.
- mem_ready in IDLE or DONE is ignored; instruction does not change.
- Latency: fetch_start at edge N puts mem_read=1 from N+1. If mem_ready=1 in the first REQ cycle, instruction_valid=1 after edge N+2. Minimum fetch latency is 2 cycles; otherwise it is 2 plus the memory wait cycles.
- Timeout example: with TIMEOUT_CYCLES=T and mem_ready never asserted, mem_read is high for exactly T cycles.
- Timeout versus data: mem_ready=1 in the same cycle as the timeout takes priority, and the data is captured.
- instruction_addr and mem_rdata values outside their qualifying cycles have no effect.

Test Plan:
- Reset, then fetch_start with instruction_addr=0x00000100 and mem_ready high in the first REQ cycle with mem_rdata=0x00500093 -> mem_read high for 1 cycle with mem_addr=0x100. instruction=0x00500093 and instruction_valid=1 two cycles after fetch_start.
- fetch_start with addr=0x200 and mem_ready delayed 3 cycles, plus a second fetch_start pulse during REQ -> mem_addr stays 0x200 for 4 cycles, only one fetch completes, and fetch_busy is high for 4 cycles.
- fetch_start with addr=0x00000102 -> mem_read never asserts, misaligned_fault=1, instruction=0x00000013, instruction_valid=0. A following aligned fetch clears the fault.
- TIMEOUT_CYCLES=4, fetch to 0x300 with mem_ready held low -> mem_read high exactly 4 cycles, then bus_fault=1, instruction_valid=0, state IDLE. Repeat with mem_ready rising in the 4th cycle -> data captured and bus_fault=0.
- Assert reset in the 2nd REQ cycle while mem_ready=1 and mem_rdata=0xDEADBEEF -> after that edge all outputs equal their reset values and instruction=0x00000013.
- Pulse mem_ready with mem_rdata=0x12345678 while in DONE -> instruction keeps its previously fetched value and instruction_valid stays 1.
